// File: rtl/shift_pkg.sv
// shift_pkg: shared constants and types for the gpu2d serial shift datapath.
// Provides SHIFT_WIDTH_DEFAULT and the deserializer output-buffer state enum.
package shift_pkg;
  localparam int SHIFT_WIDTH_DEFAULT = 8;
  typedef enum logic {DESER_EMPTY, DESER_FULL} deser_state_t;
endpackage

// File: rtl/serial_deserializer.sv
// serial_deserializer: LSB-first serial-to-parallel converter with a one-word valid/ready output buffer.
// Optional macro SERIAL_DESERIALIZER_SYNC_EN adds the sync port for word realignment.
// Ports: clk; rst_n (sync, active-low); bit_in/bit_valid serial input; [sync];
//        out/out_valid/out_ready word handshake; overflow sticky dropped-word flag.
module serial_deserializer
  import shift_pkg::*;
#(
  parameter int N = SHIFT_WIDTH_DEFAULT,
  parameter int COUNTER_WIDTH = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_in,
  input  logic         bit_valid,
`ifdef SERIAL_DESERIALIZER_SYNC_EN
  input  logic         sync,
`endif
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);
  logic [COUNTER_WIDTH-1:0] counter;
  logic [N-1:0] shreg, word;
  logic clr, done, load, drop;
  deser_state_t state, state_nx;
`ifdef SERIAL_DESERIALIZER_SYNC_EN
  assign clr = sync;
`else
  assign clr = 1'b0;
`endif
  assign word = {bit_in, shreg[N-1:1]};
  // a sync restart discards the partial word, so it can never complete one
  assign done = bit_valid && !clr && counter == COUNTER_WIDTH'(N-1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      counter <= '0;
      shreg <= '0;
    end else if (clr) begin
      counter <= bit_valid ? COUNTER_WIDTH'(1) : '0;
      shreg <= bit_valid ? {bit_in, {(N-1){1'b0}}} : '0;
    end else if (bit_valid) begin
      counter <= counter == COUNTER_WIDTH'(N-1) ? '0 : counter + 1'b1;
      shreg <= word;
    end
  assign out_valid = state == DESER_FULL;
  // a new word may enter when the buffer is empty or is being drained this cycle
  always_comb begin
    load = done && (state == DESER_EMPTY || out_ready);
    drop = done && state == DESER_FULL && !out_ready;
    state_nx = load ? DESER_FULL : (state == DESER_FULL && out_ready) ? DESER_EMPTY : state;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= DESER_EMPTY;
      out <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      out <= load ? word : out;
      overflow <= overflow | drop;
    end
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed, self-checking bench for serial_deserializer (N=8).
module tb_serial_deserializer;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, bit_in = 0, bit_valid = 0, out_ready = 0, sync = 0;
  logic [N-1:0] out;
  logic out_valid, overflow;
  int n_chk = 0, n_fail = 0, words = 0, w0;
  logic en = 0;
  logic [N-1:0] m_out, m_acc, m_w;
  logic m_valid, m_ovf, m_xfer, m_comp;
  int m_nb;
  always #5 clk = ~clk;
  serial_deserializer #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
`ifdef SERIAL_DESERIALIZER_SYNC_EN
    .sync(sync),
`endif
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow)
  );
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // word-level model: collect bits, form a word every N accepted bits, single-slot buffer
  task automatic model();
    if (!rst_n) begin
      m_nb = 0; m_acc = '0; m_out = '0; m_valid = 0; m_ovf = 0;
    end else begin
      m_xfer = m_valid && out_ready;
      m_comp = 0;
`ifdef SERIAL_DESERIALIZER_SYNC_EN
      if (sync) begin m_nb = 0; m_acc = '0; end
`endif
      if (bit_valid) begin
        m_acc[m_nb] = bit_in;
        m_nb++;
        if (m_nb == N) begin m_comp = 1; m_w = m_acc; m_nb = 0; m_acc = '0; end
      end
      if (m_xfer) m_valid = 0;
      if (m_comp) begin
        if (m_valid) m_ovf = 1;
        else begin m_out = m_w; m_valid = 1; end
      end
    end
  endtask
  always @(negedge clk)
    if (en) begin
      chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
      chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
      chk("out", out, m_out);
      if (out_valid && out_ready) words++;
    end
  task automatic step(input logic rn, input logic bv, input logic bi, input logic rdy, input logic sy);
    rst_n = rn; bit_valid = bv; bit_in = bi; out_ready = rdy; sync = sy;
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  task automatic send(input logic [N-1:0] v, input logic rdy, input logic rdy_last);
    for (int i = 0; i < N; i++) step(1, 1, v[i], i == N-1 ? rdy_last : rdy, 0);
  endtask
  initial begin
    logic [N-1:0] v;
    @(negedge clk);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    en = 1;
    chk("rst_out", out, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_ovf", {7'b0, overflow}, 8'h00);
    send(8'h4D, 1, 1);
    chk("b2b_out", out, 8'h4D);
    chk("b2b_valid", {7'b0, out_valid}, 8'h01);
    chk("model_b2b", m_out, 8'h4D);
    step(1, 0, 0, 1, 0);
    v = 8'h4D;
    for (int i = 0; i < N; i++) begin
      step(1, 0, 0, 1, 0);
      step(1, 1, v[i], 1, 0);
    end
    chk("gap_out", out, 8'h4D);
    chk("gap_valid", {7'b0, out_valid}, 8'h01);
    step(1, 0, 0, 1, 0);
    send(8'hA5, 0, 0);
    chk("bp_first", out, 8'hA5);
    chk("bp_no_ovf", {7'b0, overflow}, 8'h00);
    send(8'h3C, 0, 0);
    chk("bp_hold", out, 8'hA5);
    chk("bp_ovf", {7'b0, overflow}, 8'h01);
    chk("model_ovf", {7'b0, m_ovf}, 8'h01);
    step(1, 0, 0, 1, 0);
    chk("bp_drain_valid", {7'b0, out_valid}, 8'h00);
    chk("bp_stale", out, 8'hA5);
    step(0, 0, 0, 0, 0);
    send(8'h11, 0, 0);
    chk("sim_first", out, 8'h11);
    send(8'h22, 0, 1);
    chk("sim_out", out, 8'h22);
    chk("sim_valid", {7'b0, out_valid}, 8'h01);
    chk("sim_ovf", {7'b0, overflow}, 8'h00);
    step(1, 0, 0, 1, 0);
`ifdef SERIAL_DESERIALIZER_SYNC_EN
    w0 = words;
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    chk("sync_words", 8'(words - w0), 8'h01);
    chk("sync_out", out, 8'h01);
`endif
    w0 = words;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("mrst_out", out, 8'h00);
    chk("mrst_valid", {7'b0, out_valid}, 8'h00);
    chk("mrst_ovf", {7'b0, overflow}, 8'h00);
    send(8'hFF, 1, 1);
    chk("mrst_word", out, 8'hFF);
    chk("mrst_wvalid", {7'b0, out_valid}, 8'h01);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    chk("mrst_words", 8'(words - w0), 8'h01);
    en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel converter that rebuilds N-bit words from a qualified serial bit stream, shifted in LSB first. It is the receiving end of the parallel-to-serial shift register used on the gpu2d pixel/data paths. It sits between a serial link or test port and word-wide consumers such as FIFOs and register files. Completed words are presented through a single-entry valid/ready output buffer with sticky overflow detection.

## Interface
- `N`, default 8: word width in bits; must be ≥ 2.
- `COUNTER_WIDTH`, default `$clog2(N)`: bit-counter width.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `bit_in`  in  1: serial data bit.
- `bit_valid`  in  1: `bit_in` is sampled this cycle.
- `sync`  in  1: word-alignment restart; present only with `SERIAL_DESERIALIZER_SYNC_EN`.
- `out`  out  N: assembled word.
- `out_valid`  out  1: `out` holds an unconsumed word.
- `out_ready`  in  1: consumer accepts `out` this cycle.
- `overflow`  out  1: sticky flag; a completed word was dropped.

## Operation
- Reset values (when `rst_n`=0 at a clock edge):
  - `counter`=0, `shreg`=0
  - `out`=0, `out_valid`=0, `overflow`=0
- Bit accept (`bit_valid`=1):
  - `shreg <= {bit_in, shreg[N-1:1]}`, so the first bit received ends in bit 0.
  - `counter` increments; it wraps from N-1 to 0.
  - `bit_valid`=0 holds both `shreg` and `counter`.
- Word completion: a bit is accepted while `counter`==N-1. The completed word is `{bit_in, shreg[N-1:1]}`.
- Output buffer is a two-state machine:
  - EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - Handshake: a transfer occurs when `out_valid`=1 and `out_ready`=1.
  - EMPTY + completion: load `out`, go to FULL.
  - FULL + transfer + completion in the same cycle: load the new word, stay FULL (no bubble, no overflow).
  - FULL + transfer, no completion: go to EMPTY; `out` keeps its stale value.
  - FULL + no transfer + completion: drop the new word, set `overflow`, keep `out` unchanged.
- `overflow` clears only on reset.
- `out` and `out_valid` must not change while `out_valid`=1 and `out_ready`=0, except via reset.
- `out_ready` is ignored while `out_valid`=0.

## Timing
- Latency: Nth bit accepted at edge t means `out_valid`=1 with the word on `out` after edge t, i.e. from cycle t+1.
- Throughput: one word per N `bit_valid` cycles, sustained with `out_ready` held at 1.
- `overflow` rises in the cycle after the dropping edge.
- Reset mid-word discards the partial word and any buffered word. The first bit after reset is bit 0.

## Configuration
- `SERIAL_DESERIALIZER_SYNC_EN` defined:
  - Adds the `sync` port.
  - `sync`=1 discards the partial word: `shreg` is cleared and `counter` is set to 0.
  - If `bit_valid`=1 in the same cycle, that bit becomes bit 0 of the new word (`counter` becomes 1).
  - `sync` does not affect the output buffer or `overflow`.
- Macro undefined: no `sync` port; word alignment is established only by reset.

## Structure
- Shared package `shift_pkg`:
  - `SHIFT_WIDTH_DEFAULT` (=8).
  - Output-buffer state enum `deser_state_t` {`DESER_EMPTY`, `DESER_FULL`}.
- Single module, no sub-modules. Assembly and buffer logic stay as separate `always_ff` blocks.

## Test plan
All scenarios use N=8.
- Back-to-back bits: bits 1,0,1,1,0,0,1,0 on consecutive cycles, `out_ready`=1 -> `out`=8'h4D and `out_valid`=1 one cycle after the 8th bit.
- Gapped input: same bits with `bit_valid` low on alternate cycles -> `out`=8'h4D; no early `out_valid`.
- Backpressure: `out_ready`=0, send 8'hA5 then 8'h3C -> `out` stays 8'hA5; `overflow`=1 after the 16th bit; 8'h3C is never seen.
- Simultaneous drain and completion: `out`=8'h11 FULL, `out_ready`=1 on the 8th bit of 8'h22 -> next cycle `out`=8'h22, `out_valid`=1, `overflow`=0.
- Sync (macro on): 3 bits of 1, then `sync`=1 with `bit_valid`=1 and `bit_in`=1, then 7 zero bits -> exactly one word, `out`=8'h01.
- Mid-word reset: 5 bits of 1, then `rst_n`=0 for one cycle (all outputs 0), then 8 bits of 1 -> exactly one word 8'hFF.
